decoder_pipe: RTL and testbench

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pipe_if.sv | 27 ++
 rtl/decoder_pipe.sv | 93 +++++++++
 tb/tb_decoder_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_if.sv
// Handshake bundle between a code producer, the decoder buffer and a word consumer.
// Producer drives x/mode/in_valid, consumer drives out_ready.
interface decoder_pipe_if #(
    parameter int WIDTH = 2
);
    localparam int N = 2 ** WIDTH;

    logic [WIDTH-1:0] x;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     y;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [7:0]       count;

    modport master (
        output x, mode, in_valid, out_ready,
        input  in_ready, y, out_valid, err, count
    );

    modport slave (
        input  x, mode, in_valid, out_ready,
        output in_ready, y, out_valid, err, count
    );
endinterface

// File: rtl/decoder_pipe.sv
// Code decoder (one-hot / thermometer / inverted one-hot) feeding a small FIFO.
// Decode happens at acceptance; the FIFO head drives y one cycle later.
module decoder_pipe #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    decoder_pipe_if.slave bus
);
    localparam int N  = 2 ** WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [7:0]    count_q, count_d;
    logic          err_q, err_d;
    logic          acc, rem, in_ready, out_valid;
    logic [N-1:0]  dec_word;

    function automatic logic [N-1:0] decode(input logic [WIDTH-1:0] code,
                                            input logic [1:0]       md);
        logic [N-1:0] oh;
        logic [N-1:0] th;
        oh = '0;
        th = '0;
        oh[code] = 1'b1;
        for (int i = 0; i < N; i++) begin
            th[i] = (i <= int'(code));
        end
        case (md)
            2'b01:   decode = th;
            2'b10:   decode = ~oh;
            default: decode = oh;  // reserved mode decodes as one-hot
        endcase
    endfunction

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (occ_q < OW'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign acc       = bus.in_valid && in_ready;
    assign rem       = out_valid && bus.out_ready;
    assign dec_word  = decode(bus.x, bus.mode);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        count_d  = count_q;
        err_d    = err_q;
        if (acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + 8'd1;
            if (bus.mode == 2'b11) err_d = 1'b1;
        end
        if (rem) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({acc, rem})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once occupancy is cleared
    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_ptr_q] <= dec_word;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: a WIDTH=2 and a WIDTH=3 instance, both DEPTH=2.
module tb_decoder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    decoder_pipe_if #(.WIDTH(2)) b2 ();
    decoder_pipe_if #(.WIDTH(3)) b3 ();

    decoder_pipe #(.WIDTH(2), .DEPTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    decoder_pipe #(.WIDTH(3), .DEPTH(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [1:0] md, input logic [1:0] xv,
                          input logic ordy);
        b2.in_valid  = v;
        b2.mode      = md;
        b2.x         = xv;
        b2.out_ready = ordy;
    endtask

    logic [3:0] exp_oh;

    initial begin
        drive2(1'b0, 2'b00, 2'd0, 1'b0);
        b3.in_valid  = 1'b0;
        b3.mode      = 2'b00;
        b3.x         = 3'd0;
        b3.out_ready = 1'b1;

        // reset values while rst_n is held low
        #12;
        chk("rst_in_ready", 32'(b2.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
        chk("rst_y", 32'(b2.y), 32'd0);
        chk("rst_err", 32'(b2.err), 32'd0);
        chk("rst_count", 32'(b2.count), 32'd0);
        rst_n = 1'b1;

        // one-hot stream with out_ready=1, plus WIDTH=3 thermometer/inverted
        drive2(1'b1, 2'b00, 2'd0, 1'b1);
        b3.in_valid = 1'b1; b3.mode = 2'b01; b3.x = 3'd5;
        tick();
        chk("oh_x0", 32'(b2.y), 32'h1);
        chk("oh_x0_valid", 32'(b2.out_valid), 32'd1);
        chk("w3_therm5", 32'(b3.y), 32'h3F);
        b3.mode = 2'b10; b3.x = 3'd0;
        b2.x = 2'd1;
        tick();
        chk("oh_x1", 32'(b2.y), 32'h2);
        chk("w3_inv0", 32'(b3.y), 32'hFE);
        b3.in_valid = 1'b0;
        b2.x = 2'd2;
        tick();
        chk("oh_x2", 32'(b2.y), 32'h4);
        b2.x = 2'd3;
        tick();
        chk("oh_x3", 32'(b2.y), 32'h8);
        b2.in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(b2.out_valid), 32'd0);
        chk("drain_y", 32'(b2.y), 32'd0);
        chk("count4", 32'(b2.count), 32'd4);
        chk("w3_drain", 32'(b3.out_valid), 32'd0);

        // empty buffer: out_ready has no effect
        tick();
        chk("empty_valid", 32'(b2.out_valid), 32'd0);
        chk("empty_ready", 32'(b2.in_ready), 32'd1);

        // thermometer and inverted one-hot on WIDTH=2
        drive2(1'b1, 2'b01, 2'd1, 1'b1);
        tick();
        chk("therm1", 32'(b2.y), 32'h3);
        drive2(1'b1, 2'b10, 2'd2, 1'b1);
        tick();
        chk("inv2", 32'(b2.y), 32'hB);
        drive2(1'b0, 2'b00, 2'd0, 1'b1);
        tick();
        chk("count6", 32'(b2.count), 32'd6);

        // backpressure: fill DEPTH=2, third offer must stall
        drive2(1'b1, 2'b00, 2'd1, 1'b0);
        tick();
        chk("bp_ready1", 32'(b2.in_ready), 32'd1);
        b2.x = 2'd2;
        tick();
        chk("bp_full_ready", 32'(b2.in_ready), 32'd0);
        chk("bp_head", 32'(b2.y), 32'h2);
        b2.x = 2'd3;
        tick();
        chk("bp_stall_count", 32'(b2.count), 32'd8);
        chk("bp_stall_ready", 32'(b2.in_ready), 32'd0);
        // full with in_valid and out_ready together: only a remove happens
        b2.out_ready = 1'b1;
        tick();
        chk("bp_pop1", 32'(b2.y), 32'h4);
        chk("bp_ready_back", 32'(b2.in_ready), 32'd1);
        chk("bp_no_accept", 32'(b2.count), 32'd8);
        tick();
        chk("bp_third", 32'(b2.y), 32'h8);
        chk("bp_count9", 32'(b2.count), 32'd9);
        b2.in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(b2.out_valid), 32'd0);

        // reserved mode sets sticky err
        drive2(1'b1, 2'b11, 2'd1, 1'b1);
        tick();
        chk("rsv_y", 32'(b2.y), 32'h2);
        chk("rsv_err", 32'(b2.err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive2(1'b1, 2'b00, 2'(i), 1'b1);
            exp_oh = 4'b0001 << (i % 4);
            tick();
            chk("err_sticky", 32'(b2.err), 32'd1);
            chk("loop_y", 32'(b2.y), 32'(exp_oh));
        end
        chk("count20", 32'(b2.count), 32'd20);
        for (int i = 0; i < 236; i++) tick();
        chk("count_wrap", 32'(b2.count), 32'd0);
        b2.in_valid = 1'b0;
        tick();

        // asynchronous reset with two entries held
        drive2(1'b1, 2'b00, 2'd0, 1'b0);
        tick();
        b2.x = 2'd3;
        tick();
        b2.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(b2.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(b2.out_valid), 32'd0);
        chk("async_y", 32'(b2.y), 32'd0);
        chk("async_ready", 32'(b2.in_ready), 32'd1);
        chk("async_err", 32'(b2.err), 32'd0);
        chk("async_count", 32'(b2.count), 32'd0);
        rst_n = 1'b1;
        drive2(1'b1, 2'b00, 2'd2, 1'b1);
        tick();
        chk("post_rst_y", 32'(b2.y), 32'h4);
        chk("post_rst_count", 32'(b2.count), 32'd1);
        b2.in_valid = 1'b0;
        tick();
        chk("post_rst_stale", 32'(b2.out_valid), 32'd0);
        chk("post_rst_y0", 32'(b2.y), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
